// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched: two-requester round-robin register-file writeback
// scheduler with a per-register pending-write scoreboard.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   req0_valid/addr/data, req0_ready  ALU writeback requester
//   req1_valid/addr/data, req1_ready  load writeback requester
//   issue_valid/addr, issue_stall   destination-register claim from issue
//   write_enable/addr/data          registered register-file write port
//   busy                            pending-write scoreboard, bit n = reg n
module regfile_wb_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [5:0]  req0_addr,
    input  logic [63:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [5:0]  req1_addr,
    input  logic [63:0] req1_data,
    output logic        req1_ready,
    input  logic        issue_valid,
    input  logic [5:0]  issue_addr,
    output logic        issue_stall,
    output logic        write_enable,
    output logic [5:0]  write_addr,
    output logic [63:0] write_data,
    output logic [63:0] busy
);

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned NREGS  = 64;

    // r_prio = 0 favours requester 0 on contention, 1 favours requester 1
    logic              r_prio;
    logic [NREGS-1:0]  r_busy;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;

    logic              w_grant0;
    logic              w_grant1;
    logic              w_issue_ok;
    logic [NREGS-1:0]  w_clr_mask;
    logic [NREGS-1:0]  w_set_mask;
    logic [NREGS-1:0]  w_busy_nxt;

    // Arbitration: a lone requester always wins; contention follows r_prio.
    // Nothing is granted while reset is held.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (rst_n) begin
            if (req0_valid && req1_valid) begin
                w_grant0 = ~r_prio;
                w_grant1 = r_prio;
            end else begin
                w_grant0 = req0_valid;
                w_grant1 = req1_valid;
            end
        end
    end

    // Stall looks only at the pre-edge scoreboard, so a same-cycle clear
    // never releases an issue.
    assign issue_stall = issue_valid & r_busy[issue_addr];
    assign w_issue_ok  = issue_valid & ~r_busy[issue_addr];

    // Scoreboard update: clears from accepted writes, then sets from
    // accepted issues so a colliding set wins.
    always_comb begin
        w_clr_mask = '0;
        w_set_mask = '0;
        if (w_grant0) begin
            w_clr_mask[req0_addr] = 1'b1;
        end
        if (w_grant1) begin
            w_clr_mask[req1_addr] = 1'b1;
        end
        if (w_issue_ok) begin
            w_set_mask[issue_addr] = 1'b1;
        end
        w_busy_nxt = (r_busy & ~w_clr_mask) | w_set_mask;
    end

    // State and registered write port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prio  <= 1'b0;
            r_busy  <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_we   <= w_grant0 | w_grant1;
            if (w_grant0) begin
                r_prio  <= 1'b1;
                r_waddr <= req0_addr;
                r_wdata <= req0_data;
            end else if (w_grant1) begin
                r_prio  <= 1'b0;
                r_waddr <= req1_addr;
                r_wdata <= req1_data;
            end
        end
    end

    assign req0_ready   = w_grant0;
    assign req1_ready   = w_grant1;
    assign write_enable = r_we;
    assign write_addr   = r_waddr;
    assign write_data   = r_wdata;
    assign busy         = r_busy;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Testbench for regfile_wb_sched: directed scenarios plus randomized
// traffic, all checked against a behavioural model of the scheduler.
module tb_regfile_wb_sched;

    logic        clk;
    logic        rst_n;
    logic        req0_valid;
    logic [5:0]  req0_addr;
    logic [63:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [5:0]  req1_addr;
    logic [63:0] req1_data;
    logic        req1_ready;
    logic        issue_valid;
    logic [5:0]  issue_addr;
    logic        issue_stall;
    logic        write_enable;
    logic [5:0]  write_addr;
    logic [63:0] write_data;
    logic [63:0] busy;

    int n_total;
    int n_bad;

    // Behavioural model state
    bit          m_busy [64];
    int          m_favour;      // requester that wins the next contention
    bit          m_we;
    logic [5:0]  m_waddr;
    logic [63:0] m_wdata;
    bit          last_g0;
    bit          last_g1;

    regfile_wb_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req0_addr    (req0_addr),
        .req0_data    (req0_data),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_addr    (req1_addr),
        .req1_data    (req1_data),
        .req1_ready   (req1_ready),
        .issue_valid  (issue_valid),
        .issue_addr   (issue_addr),
        .issue_stall  (issue_stall),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_busy_vec();
        logic [63:0] v;
        for (int i = 0; i < 64; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_busy[i] = 1'b0;
        m_favour = 0;
        m_we     = 1'b0;
        m_waddr  = '0;
        m_wdata  = '0;
    endtask

    // One clock: compare at the falling edge, then advance the model across
    // the rising edge and return 1 time unit after it.
    task automatic step();
        bit g0, g1, stall;
        @(negedge clk);
        g0 = 1'b0;
        g1 = 1'b0;
        if (rst_n) begin
            if (req0_valid && req1_valid) begin
                if (m_favour == 0) g0 = 1'b1;
                else               g1 = 1'b1;
            end else if (req0_valid) begin
                g0 = 1'b1;
            end else if (req1_valid) begin
                g1 = 1'b1;
            end
        end
        stall = issue_valid && m_busy[issue_addr];
        chk("req0_ready", 64'(req0_ready), 64'(g0));
        chk("req1_ready", 64'(req1_ready), 64'(g1));
        chk("issue_stall", 64'(issue_stall), 64'(stall));
        chk("busy", busy, model_busy_vec());
        chk("write_enable", 64'(write_enable), 64'(m_we));
        chk("write_addr", 64'(write_addr), 64'(m_waddr));
        chk("write_data", write_data, m_wdata);
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            m_we = g0 || g1;
            if (g0) begin
                m_waddr = req0_addr;
                m_wdata = req0_data;
                m_busy[req0_addr] = 1'b0;
                m_favour = 1;
            end
            if (g1) begin
                m_waddr = req1_addr;
                m_wdata = req1_data;
                m_busy[req1_addr] = 1'b0;
                m_favour = 0;
            end
            if (issue_valid && !stall) m_busy[issue_addr] = 1'b1;
        end
        last_g0 = g0;
        last_g1 = g1;
        #1;
    endtask

    task automatic idle();
        req0_valid  = 1'b0;
        req1_valid  = 1'b0;
        issue_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [5:0] exp_seq [4];
        n_total = 0;
        n_bad   = 0;
        model_reset();
        last_g0 = 1'b0;
        last_g1 = 1'b0;
        rst_n       = 1'b0;
        req0_addr   = '0;
        req0_data   = '0;
        req1_addr   = '0;
        req1_data   = '0;
        issue_addr  = '0;
        idle();
        step();
        step();
        rst_n = 1'b1;
        step();

        // Single requester 0 write, visible the cycle after acceptance
        req0_valid = 1'b1;
        req0_addr  = 6'd5;
        req0_data  = 64'hA5A5A5A5A5A5A5A5;
        step();
        chk("s19_we", 64'(write_enable), 64'd1);
        chk("s19_addr", 64'(write_addr), 64'd5);
        chk("s19_data", write_data, 64'hA5A5A5A5A5A5A5A5);
        idle();
        step();

        // Contention from reset: alternating grants, no bubbles
        do_reset();
        exp_seq[0] = 6'd1; exp_seq[1] = 6'd2; exp_seq[2] = 6'd1; exp_seq[3] = 6'd2;
        req0_valid = 1'b1; req0_addr = 6'd1; req0_data = 64'h1111;
        req1_valid = 1'b1; req1_addr = 6'd2; req1_data = 64'h2222;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("s20_we", 64'(write_enable), 64'd1);
            chk("s20_addr", 64'(write_addr), 64'(exp_seq[i]));
        end
        idle();
        step();

        // Issue to 63, re-issue stalls, load write clears it
        issue_valid = 1'b1; issue_addr = 6'd63;
        step();
        chk("s21_set", 64'(busy[63]), 64'd1);
        step();
        issue_valid = 1'b0;
        req1_valid = 1'b1; req1_addr = 6'd63; req1_data = 64'h6363;
        step();
        chk("s21_clr", 64'(busy[63]), 64'd0);
        idle();

        // Same-cycle clear and issue on register 10
        issue_valid = 1'b1; issue_addr = 6'd10;
        step();
        req0_valid = 1'b1; req0_addr = 6'd10; req0_data = 64'h1010;
        step();
        chk("s22_stalled_clear", 64'(busy[10]), 64'd0);
        step();
        chk("s22_set_wins", 64'(busy[10]), 64'd1);
        idle();
        step();

        // Mid-operation reset drops scoreboard and pending write
        issue_valid = 1'b1; issue_addr = 6'd20;
        step();
        issue_valid = 1'b0;
        req1_valid = 1'b1; req1_addr = 6'd3; req1_data = 64'h3333;
        rst_n = 1'b0;
        step();
        chk("s23_busy", busy, 64'd0);
        chk("s23_we", 64'(write_enable), 64'd0);
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_addr = 6'd4; req0_data = 64'h4444;
        step();
        chk("s23_grant0", 64'(write_addr), 64'd4);
        idle();
        step();

        // Register 0 is an ordinary register
        req0_valid = 1'b1; req0_addr = 6'd0; req0_data = 64'hDEADBEEFDEADBEEF;
        step();
        chk("s24_we", 64'(write_enable), 64'd1);
        chk("s24_addr", 64'(write_addr), 64'd0);
        chk("s24_data", write_data, 64'hDEADBEEFDEADBEEF);
        idle();
        step();

        // Randomized traffic; requests stay stable until accepted
        for (int c = 0; c < 600; c++) begin
            if (!req0_valid || last_g0) begin
                req0_valid = ($urandom_range(0, 3) != 0);
                req0_addr  = 6'($urandom_range(0, 15));
                req0_data  = {$urandom, $urandom};
            end
            if (!req1_valid || last_g1) begin
                req1_valid = ($urandom_range(0, 3) != 0);
                req1_addr  = 6'($urandom_range(0, 15));
                req1_data  = {$urandom, $urandom};
            end
            issue_valid = ($urandom_range(0, 1) != 0);
            issue_addr  = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(16, 63))
                                                       : 6'($urandom_range(0, 15));
            rst_n = ($urandom_range(0, 99) != 0);
            step();
        end
        rst_n = 1'b1;
        idle();
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_sched.md
REGFILE_WB_SCHED -- requirements
Module: regfile_wb_sched

Interface
REQ-001 The interface SHALL be exactly the ports below; one clock; reset is synchronous and active-low.
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  synchronous active-low reset.
- req0_valid  input  1  requester 0 (ALU writeback) has a write pending.
- req0_addr  input  6  requester 0 destination register.
- req0_data  input  64  requester 0 write data.
- req0_ready  output  1  requester 0 write accepted this cycle.
- req1_valid  input  1  requester 1 (load writeback) has a write pending.
- req1_addr  input  6  requester 1 destination register.
- req1_data  input  64  requester 1 write data.
- req1_ready  output  1  requester 1 write accepted this cycle.
- issue_valid  input  1  an instruction claims a destination register.
- issue_addr  input  6  destination register being claimed.
- issue_stall  output  1  claim refused because the destination is already busy.
- write_enable  output  1  register-file write strobe.
- write_addr  output  6  register-file write address.
- write_data  output  64  register-file write data.
- busy  output  64  per-register pending-write scoreboard; bit n covers register n.

Function
REQ-002 A transfer on requester k SHALL occur on a cycle where reqk_valid and reqk_ready are both 1; reqk_ready SHALL be combinational from the valid inputs and the priority state.
REQ-003 At most one of req0_ready and req1_ready SHALL be 1 per cycle; if exactly one valid is high, that requester SHALL be granted.
REQ-004 If both valids are high, the requester named by the 1-bit priority pointer SHALL be granted; after any grant the pointer SHALL point to the non-granted requester (round robin).
REQ-005 A requester SHALL hold valid, addr and data stable until accepted; the block need not check this.
REQ-006 write_enable, write_addr and write_data SHALL be registered: a transfer accepted at edge N SHALL drive them during the cycle after edge N, one write per cycle.
REQ-007 On a cycle with no transfer, write_enable SHALL be 0 at the next edge; write_addr and write_data SHALL hold their last values.
REQ-008 Back-to-back transfers SHALL sustain one write per cycle with no bubble.
REQ-009 issue_stall SHALL equal issue_valid AND busy[issue_addr] (combinational).
REQ-010 An issue with issue_valid=1 and issue_stall=0 SHALL set busy[issue_addr] at the next edge.
REQ-011 A transfer SHALL clear busy[reqk_addr] at the accepting edge.
REQ-012 A transfer to a register whose busy bit is 0 SHALL still be accepted and written; busy stays 0.
REQ-013 If a transfer clears and a non-stalled issue sets the same address on the same edge, set SHALL win and the bit SHALL be 1.
REQ-014 The combinational issue_stall SHALL use the pre-edge busy value; a same-cycle clear SHALL NOT un-stall an issue.
REQ-015 Register 0 SHALL have no special treatment; all 64 addresses behave identically.

Reset
REQ-016 While rst_n=0 at an edge: busy=0, write_enable=0, write_addr=0, write_data=0, priority pointer favours requester 0.
REQ-017 During reset, req0_ready and req1_ready SHALL be 0 and no transfer or issue SHALL be recorded.
REQ-018 Reset asserted mid-operation SHALL discard all pending busy bits and any registered write not yet presented.

Verification
REQ-019 Scenario: only req0_valid, addr 5, data A5A5A5A5A5A5A5A5 -> req0_ready=1 that cycle; next cycle write_enable=1, write_addr=5, write_data=A5A5A5A5A5A5A5A5.
REQ-020 Scenario: both valid for 4 cycles from reset (addrs 1 and 2) -> grants 0,1,0,1; write_enable high 4 consecutive cycles.
REQ-021 Scenario: issue addr 63 -> busy[63]=1; second issue to 63 -> issue_stall=1; req1 write to 63 accepted -> busy[63]=0 after edge.
REQ-022 Scenario: busy[10]=1, same cycle req0 write to 10 and issue to 10 -> issue_stall=1 and busy[10]=0 after edge; with busy[10]=0 at start, the issue is accepted and busy[10]=1 after edge.
REQ-023 Scenario: rst_n=0 for one edge with busy nonzero and a write pending -> busy=0, write_enable=0, next contention grants req0.
REQ-024 Scenario: write to register 0 with data DEADBEEFDEADBEEF -> write_addr=0, write_data=DEADBEEFDEADBEEF, write_enable=1 one cycle later.
